// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared types and address-mapping helpers for the SDRAM arbiter.
//   state_t  : arbiter FSM state (IDLE, BUSY)
//   src_t    : which requester owns the access in flight
//   map_cpu  : Z80 address -> SDRAM byte address (ROM shadow below 4000)
//   map_vid  : screen offset -> SDRAM byte address (inside the CPU RAM map)
//   Addresses are computed at 32 bits; callers truncate to their own width.
package mem_pkg;

   typedef enum logic {IDLE, BUSY} state_t;

   typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_LDR} src_t;

   localparam logic [23:0] ROM_BASE_DEF = 24'h000000;
   localparam logic [23:0] RAM_BASE_DEF = 24'h010000;
   localparam logic [15:0] ROM_TOP      = 16'h4000;   // CPU 0000-3FFF is ROM
   localparam logic [15:0] VID_OFS      = 16'h4000;   // screen lives at CPU 4000

   function automatic logic [31:0] map_cpu(input logic [15:0] ca,
                                           input logic [31:0] rom_base,
                                           input logic [31:0] ram_base);
      return (ca < ROM_TOP) ? rom_base + {16'h0, ca} : ram_base + {16'h0, ca};
   endfunction

   function automatic logic [31:0] map_vid(input logic [12:0] va,
                                           input logic [31:0] ram_base);
      return ram_base + {16'h0, VID_OFS} + {19'h0, va};
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: every requester and sequencer signal of the arbiter.
//   slave  : arbiter view (takes requests, drives the sequencer command)
//   master : system view (requesters, mist_io loader and SDRAM sequencer)
// Signals:
//   ready                     SDRAM init complete
//   vreq/va -> vq/vvalid      video fetch
//   creq/cwe/ca/cd -> cq/cack CPU access
//   lwr/la/ld -> lfull        loader writes
//   err                       sticky dropped-write / video overrun
//   sreq/swe/sa/sd <- sq/sack sequencer command and completion
interface mem_arbiter_if #(parameter int AW = 24);
   logic          ready;
   logic          vreq;
   logic [12:0]   va;
   logic [7:0]    vq;
   logic          vvalid;
   logic          creq;
   logic          cwe;
   logic [15:0]   ca;
   logic [7:0]    cd;
   logic [7:0]    cq;
   logic          cack;
   logic          lwr;
   logic [AW-1:0] la;
   logic [7:0]    ld;
   logic          lfull;
   logic          err;
   logic          sreq;
   logic          swe;
   logic [AW-1:0] sa;
   logic [7:0]    sd;
   logic [7:0]    sq;
   logic          sack;

   modport slave (
      input  ready, vreq, va, creq, cwe, ca, cd, lwr, la, ld, sq, sack,
      output vq, vvalid, cq, cack, lfull, err, sreq, swe, sa, sd
   );

   modport master (
      output ready, vreq, va, creq, cwe, ca, cd, lwr, la, ld, sq, sack,
      input  vq, vvalid, cq, cack, lfull, err, sreq, swe, sa, sd
   );
endinterface

// File: rtl/mem_arbiter_fifo.sv
// mem_fifo: synchronous FIFO holding loader writes ({address, data}).
//   clock, reset : clock, asynchronous active-low reset
//   push/din     : write an entry (ignored when full unless popping too)
//   pop/dout     : dout is the head entry, pop advances it
//   full/empty   : occupancy flags
// Push and pop in the same cycle while full is accepted: the write slot is the
// one being vacated, and dout is read combinationally before the edge.
module mem_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wptr, rptr;    // extra MSB tells full from empty
   logic         do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[PW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[PW-1:0]] <= din;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide SDRAM command port between video fetch,
// the Z80 CPU and the ROM/image loader. One access in flight at a time.
// Priority: video > (loader if its FIFO is full) > CPU > loader.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-low; drops sreq immediately
//   bus    mem_arbiter_if.slave (requesters, loader, sequencer)
// Parameters:
//   AW        SDRAM byte-address width
//   LDEPTH    loader FIFO depth (power of 2, >= 2)
//   ROM_BASE  SDRAM base of the 16K ROM image
//   RAM_BASE  SDRAM base of the 64K CPU map
//   ROM_WP    1 = CPU writes to 0000-3FFF are discarded
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int            AW       = 24,
   parameter int            LDEPTH   = 4,
   parameter logic [AW-1:0] ROM_BASE = AW'(ROM_BASE_DEF),
   parameter logic [AW-1:0] RAM_BASE = AW'(RAM_BASE_DEF),
   parameter bit            ROM_WP   = 1'b1
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [7:0]    d;
   } req_t;

   state_t        state, state_nx;
   logic          grant;
   src_t          gsrc, gsrc_r;
   req_t          gq;

   logic          vpend;
   logic [12:0]   va_r;
   logic          cpend;
   req_t          creq_r;

   logic          cpu_wp, cpu_take, wp_dly;
   logic          vid_gnt, cpu_gnt, ldr_gnt;

   logic          f_push, f_pop, f_full, f_empty, f_drop;
   logic [AW+7:0] f_dout;

   logic          sreq_r, swe_r, vvalid_r, cack_r, err_r;
   logic [AW-1:0] sa_r;
   logic [7:0]    sd_r, vq_r, cq_r;

   // Protected ROM writes are answered locally and never become pending.
   assign cpu_wp   = ROM_WP && bus.cwe && (bus.ca < ROM_TOP);
   assign cpu_take = bus.creq && !cpu_wp;

   assign vid_gnt  = grant && (gsrc == SRC_VID);
   assign cpu_gnt  = grant && (gsrc == SRC_CPU);
   assign ldr_gnt  = grant && (gsrc == SRC_LDR);

   // Loader FIFO: a write while full survives only if the head pops this cycle.
   assign f_pop    = ldr_gnt;
   assign f_push   = bus.lwr && (!f_full || f_pop);
   assign f_drop   = bus.lwr && f_full && !f_pop;

   mem_fifo #(.W(AW + 8), .DEPTH(LDEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (f_push),
      .din   ({bus.la, bus.ld}),
      .pop   (f_pop),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      gsrc     = SRC_VID;
      case (state)
         IDLE: begin
            if (bus.ready && (vpend || cpend || !f_empty)) begin
               grant    = 1'b1;
               state_nx = BUSY;
               if (vpend)       gsrc = SRC_VID;
               else if (f_full) gsrc = SRC_LDR;   // full loader overtakes the CPU
               else if (cpend)  gsrc = SRC_CPU;
               else             gsrc = SRC_LDR;
            end
         end
         BUSY: begin
            if (bus.sack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command for the winner, mapped to an SDRAM address.
   always_comb begin
      gq = '0;
      case (gsrc)
         SRC_VID: gq = '{we: 1'b0, a: AW'(map_vid(va_r, 32'(RAM_BASE))), d: 8'h00};
         SRC_CPU: gq = creq_r;
         SRC_LDR: gq = '{we: 1'b1, a: f_dout[AW+7:8], d: f_dout[7:0]};
         default: gq = '0;
      endcase
   end

   // ---------------- pending latches ----------------
   // A new strobe wins over its own grant: the latch stays set with new data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vpend  <= 1'b0;
         va_r   <= '0;
         cpend  <= 1'b0;
         creq_r <= '0;
         wp_dly <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         if (bus.vreq) begin
            vpend <= 1'b1;
            va_r  <= bus.va;
         end else if (vid_gnt) begin
            vpend <= 1'b0;
         end

         if (cpu_take) begin
            cpend  <= 1'b1;
            creq_r <= '{we: bus.cwe,
                        a:  AW'(map_cpu(bus.ca, 32'(ROM_BASE), 32'(RAM_BASE))),
                        d:  bus.cd};
         end else if (cpu_gnt) begin
            cpend <= 1'b0;
         end

         wp_dly <= bus.creq && cpu_wp;

         // Overrun only when an unserved fetch is actually overwritten.
         if (f_drop || (bus.vreq && vpend && !vid_gnt)) err_r <= 1'b1;
      end
   end

   // ---------------- sequencer command / completion ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sreq_r   <= 1'b0;
         swe_r    <= 1'b0;
         sa_r     <= '0;
         sd_r     <= '0;
         gsrc_r   <= SRC_VID;
         vq_r     <= '0;
         vvalid_r <= 1'b0;
         cq_r     <= '0;
         cack_r   <= 1'b0;
      end else begin
         vvalid_r <= 1'b0;
         cack_r   <= wp_dly;   // protected write acks 2 cycles after creq
         if (grant) begin
            sreq_r <= 1'b1;
            swe_r  <= gq.we;
            sa_r   <= gq.a;
            sd_r   <= gq.d;
            gsrc_r <= gsrc;
         end else if (state == BUSY && bus.sack) begin
            sreq_r <= 1'b0;
            case (gsrc_r)
               SRC_VID: begin
                  vq_r     <= bus.sq;
                  vvalid_r <= 1'b1;
               end
               SRC_CPU: begin
                  if (!swe_r) cq_r <= bus.sq;
                  cack_r <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.sreq   = sreq_r;
   assign bus.swe    = swe_r;
   assign bus.sa     = sa_r;
   assign bus.sd     = sd_r;
   assign bus.vq     = vq_r;
   assign bus.vvalid = vvalid_r;
   assign bus.cq     = cq_r;
   assign bus.cack   = cack_r;
   assign bus.lfull  = f_full;
   assign bus.err    = err_r;

endmodule
